// File: rtl/alu_ctl_pkg.sv
// Shared constants and types for the ID/EX ALU issue stage: ALU control codes,
// RV32I opcodes, funct7 values and the EX slot record.
package alu_ctl_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_ADDV = 4'b0001;
  localparam logic [3:0] ALU_SUB  = 4'b0010;
  localparam logic [3:0] ALU_SUBV = 4'b0011;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0110;
  localparam logic [3:0] ALU_NOR  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_SLT  = 4'b1001;
  localparam logic [3:0] ALU_SLL  = 4'b1100;
  localparam logic [3:0] ALU_SRL  = 4'b1101;
  localparam logic [3:0] ALU_SRA  = 4'b1110;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [4:0]      rd;
    logic            wb_en;
    logic            mem_rd;
    logic            mem_wr;
    logic            is_branch;
    logic [2:0]      br_f3;
    logic            is_jump;
    logic [XLEN-1:0] store_data;
  } sideband_t;

  typedef struct packed {
    logic            valid;
    logic            illegal;
    logic [3:0]      ctl;
    logic [XLEN-1:0] da;
    logic [XLEN-1:0] db;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    sideband_t       sb;
  } ex_slot_t;

  // Register-register / register-immediate operation for the base funct7 encoding.
  function automatic logic [3:0] base_ctl(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/id_ex_alu_issue_if.sv
// ID-side inputs and EX-side outputs of the issue stage. Handshake: ID_READY is
// ~EX_STALL; an instruction moves into EX on a rising edge when ID_VALID=1 and ID_READY=1.
interface id_ex_alu_issue_if;
  logic        ID_VALID;
  logic [31:0] ID_INSTR;
  logic [31:0] ID_PC;
  logic [31:0] ID_RS1_DATA;
  logic [31:0] ID_RS2_DATA;
  logic        EX_STALL;
  logic        FLUSH;
  logic        ID_READY;
  logic        EX_VALID;
  logic [3:0]  EX_ALU_CTL;
  logic [31:0] EX_ALU_DA;
  logic [31:0] EX_ALU_DB;
  logic [31:0] EX_PC;
  logic [31:0] EX_IMM;
  logic [31:0] EX_STORE_DATA;
  logic [4:0]  EX_RD;
  logic        EX_WB_EN;
  logic        EX_MEM_RD;
  logic        EX_MEM_WR;
  logic        EX_IS_BRANCH;
  logic [2:0]  EX_BR_F3;
  logic        EX_IS_JUMP;
  logic        EX_ILLEGAL;

  modport master (
    input  ID_VALID, ID_INSTR, ID_PC, ID_RS1_DATA, ID_RS2_DATA, EX_STALL, FLUSH,
    output ID_READY, EX_VALID, EX_ALU_CTL, EX_ALU_DA, EX_ALU_DB, EX_PC, EX_IMM,
           EX_STORE_DATA, EX_RD, EX_WB_EN, EX_MEM_RD, EX_MEM_WR, EX_IS_BRANCH,
           EX_BR_F3, EX_IS_JUMP, EX_ILLEGAL
  );

  modport slave (
    output ID_VALID, ID_INSTR, ID_PC, ID_RS1_DATA, ID_RS2_DATA, EX_STALL, FLUSH,
    input  ID_READY, EX_VALID, EX_ALU_CTL, EX_ALU_DA, EX_ALU_DB, EX_PC, EX_IMM,
           EX_STORE_DATA, EX_RD, EX_WB_EN, EX_MEM_RD, EX_MEM_WR, EX_IS_BRANCH,
           EX_BR_F3, EX_IS_JUMP, EX_ILLEGAL
  );
endinterface

// File: rtl/alu_ctl_decode.sv
// Combinational RV32I decode into ALU control code, operand pair, immediate and
// EX/MEM/WB sideband. Illegal encodings come out with everything zeroed.
module alu_ctl_decode
  import alu_ctl_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic [3:0]  ctl,
  output logic [31:0] da,
  output logic [31:0] db,
  output logic [31:0] imm,
  output sideband_t   sb,
  output logic        illegal
);

  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm, shamt;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  assign i_imm  = {{20{instr[31]}}, instr[31:20]};
  assign s_imm  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign b_imm  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign u_imm  = {instr[31:12], 12'b0};
  assign j_imm  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign shamt  = {27'b0, instr[24:20]};

  logic        writes;
  logic [3:0]  ctl_d;
  logic [31:0] da_d, db_d, imm_d, sd_d;
  logic        mrd_d, mwr_d, br_d, jmp_d, bad;

  always_comb begin
    writes = 1'b0;
    ctl_d  = ALU_ADD;
    da_d   = '0;
    db_d   = '0;
    imm_d  = '0;
    sd_d   = '0;
    mrd_d  = 1'b0;
    mwr_d  = 1'b0;
    br_d   = 1'b0;
    jmp_d  = 1'b0;
    bad    = 1'b0;
    case (opcode)
      OPC_OP: begin
        da_d   = rs1;
        db_d   = rs2;
        writes = 1'b1;
        if (f7 == F7_BASE)                     ctl_d = base_ctl(f3);
        else if (f7 == F7_ALT && f3 == 3'b000) ctl_d = ALU_SUB;
        else if (f7 == F7_ALT && f3 == 3'b101) ctl_d = ALU_SRA;
        else                                   bad   = 1'b1;
      end
      OPC_OP_IMM: begin
        da_d   = rs1;
        db_d   = i_imm;
        imm_d  = i_imm;
        writes = 1'b1;
        ctl_d  = base_ctl(f3);
        // Shifts take only the 5-bit shamt; imm[11:5] selects logical vs arithmetic.
        if (f3 == 3'b001) begin
          db_d = shamt;
          if (f7 != F7_BASE) bad = 1'b1;
        end else if (f3 == 3'b101) begin
          db_d = shamt;
          if (f7 == F7_ALT)        ctl_d = ALU_SRA;
          else if (f7 != F7_BASE)  bad   = 1'b1;
        end
      end
      OPC_LOAD: begin
        da_d   = rs1;
        db_d   = i_imm;
        imm_d  = i_imm;
        mrd_d  = 1'b1;
        writes = 1'b1;
      end
      OPC_STORE: begin
        da_d  = rs1;
        db_d  = s_imm;
        imm_d = s_imm;
        sd_d  = rs2;
        mwr_d = 1'b1;
      end
      OPC_BRANCH: begin
        da_d  = rs1;
        db_d  = rs2;
        imm_d = b_imm;
        br_d  = 1'b1;
        case (f3[2:1])
          2'b00:   ctl_d = ALU_SUB;
          2'b10:   ctl_d = ALU_SLT;
          2'b11:   ctl_d = ALU_SLTU;
          default: bad   = 1'b1;
        endcase
      end
      OPC_LUI: begin
        db_d   = u_imm;
        imm_d  = u_imm;
        writes = 1'b1;
      end
      OPC_AUIPC: begin
        da_d   = pc;
        db_d   = u_imm;
        imm_d  = u_imm;
        writes = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        // Link value pc+4 is computed by the ALU; the target uses IMM in EX.
        da_d   = pc;
        db_d   = 32'd4;
        imm_d  = (opcode == OPC_JAL) ? j_imm : i_imm;
        jmp_d  = 1'b1;
        writes = 1'b1;
        if (opcode == OPC_JALR && f3 != 3'b000) bad = 1'b1;
      end
      default: bad = 1'b1;
    endcase
  end

  always_comb begin
    illegal       = bad;
    ctl           = bad ? ALU_ADD : ctl_d;
    da            = bad ? '0 : da_d;
    db            = bad ? '0 : db_d;
    imm           = bad ? '0 : imm_d;
    sb            = '0;
    if (!bad) begin
      sb.rd         = writes ? rd : 5'd0;
      sb.wb_en      = writes && (rd != 5'd0);
      sb.mem_rd     = mrd_d;
      sb.mem_wr     = mwr_d;
      sb.is_branch  = br_d;
      sb.br_f3      = br_d ? f3 : 3'b000;
      sb.is_jump    = jmp_d;
      sb.store_data = sd_d;
    end
  end

endmodule

// File: rtl/id_ex_alu_issue.sv
// ID/EX pipeline register: decodes the ID instruction and holds it for the EX
// stage, with priority reset > flush > stall > load.
module id_ex_alu_issue
  import alu_ctl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  id_ex_alu_issue_if.master bus
);

  logic [3:0]  dec_ctl;
  logic [31:0] dec_da, dec_db, dec_imm;
  sideband_t   dec_sb;
  logic        dec_illegal;
  ex_slot_t    ex_q;

  alu_ctl_decode u_decode (
    .instr   (bus.ID_INSTR),
    .pc      (bus.ID_PC),
    .rs1     (bus.ID_RS1_DATA),
    .rs2     (bus.ID_RS2_DATA),
    .ctl     (dec_ctl),
    .da      (dec_da),
    .db      (dec_db),
    .imm     (dec_imm),
    .sb      (dec_sb),
    .illegal (dec_illegal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q <= '0;
    end else if (bus.FLUSH) begin
      ex_q <= '0;
    end else if (!bus.EX_STALL) begin
      if (bus.ID_VALID) begin
        ex_q.valid   <= 1'b1;
        ex_q.illegal <= dec_illegal;
        ex_q.ctl     <= dec_ctl;
        ex_q.da      <= dec_da;
        ex_q.db      <= dec_db;
        ex_q.pc      <= bus.ID_PC;
        ex_q.imm     <= dec_imm;
        ex_q.sb      <= dec_sb;
      end else begin
        ex_q <= '0;
      end
    end
  end

  assign bus.ID_READY      = ~bus.EX_STALL;
  assign bus.EX_VALID      = ex_q.valid;
  assign bus.EX_ILLEGAL    = ex_q.illegal;
  assign bus.EX_ALU_CTL    = ex_q.ctl;
  assign bus.EX_ALU_DA     = ex_q.da;
  assign bus.EX_ALU_DB     = ex_q.db;
  assign bus.EX_PC         = ex_q.pc;
  assign bus.EX_IMM        = ex_q.imm;
  assign bus.EX_STORE_DATA = ex_q.sb.store_data;
  assign bus.EX_RD         = ex_q.sb.rd;
  assign bus.EX_WB_EN      = ex_q.sb.wb_en;
  assign bus.EX_MEM_RD     = ex_q.sb.mem_rd;
  assign bus.EX_MEM_WR     = ex_q.sb.mem_wr;
  assign bus.EX_IS_BRANCH  = ex_q.sb.is_branch;
  assign bus.EX_BR_F3      = ex_q.sb.br_f3;
  assign bus.EX_IS_JUMP    = ex_q.sb.is_jump;

endmodule

// File: tb/tb_id_ex_alu_issue.sv
// Directed bench for id_ex_alu_issue: a vector table of instructions with
// hand-computed EX outputs, plus stall/flush/reset sequences.
module tb_id_ex_alu_issue;

  typedef struct {
    logic [31:0] instr, pc, rs1, rs2;
    logic [3:0]  ctl;
    logic [31:0] da, db, imm, sd;
    logic [4:0]  rd;
    logic        wb, mrd, mwr, br;
    logic [2:0]  f3;
    logic        jmp, ill;
  } vec_t;

  localparam int NVEC = 18;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  vec_t vecs [NVEC];

  id_ex_alu_issue_if bus ();

  id_ex_alu_issue dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [179:0] got_pack();
    return {bus.EX_VALID, bus.EX_ILLEGAL, bus.EX_ALU_CTL, bus.EX_ALU_DA, bus.EX_ALU_DB,
            bus.EX_PC, bus.EX_IMM, bus.EX_STORE_DATA, bus.EX_RD, bus.EX_WB_EN,
            bus.EX_MEM_RD, bus.EX_MEM_WR, bus.EX_IS_BRANCH, bus.EX_BR_F3, bus.EX_IS_JUMP};
  endfunction

  function automatic logic [179:0] exp_pack(input vec_t v);
    return {1'b1, v.ill, v.ctl, v.da, v.db, v.pc, v.imm, v.sd, v.rd, v.wb,
            v.mrd, v.mwr, v.br, v.f3, v.jmp};
  endfunction

  task automatic check(input string name, input logic [179:0] got, input logic [179:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b expected=%b", name, got, exp);
    end
  endtask

  // Driver: present one instruction between edges
  task automatic drive(input logic valid, input vec_t v);
    bus.ID_VALID    = valid;
    bus.ID_INSTR    = v.instr;
    bus.ID_PC       = v.pc;
    bus.ID_RS1_DATA = v.rs1;
    bus.ID_RS2_DATA = v.rs2;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    //           instr         pc        rs1           rs2        ctl   da            db            imm           sd        rd  wb mrd mwr br f3  jmp ill
    vecs[0]  = '{32'h002081B3, 32'h100,  32'd5,        32'd7,     4'h0, 32'd5,        32'd7,        32'd0,        32'd0,    5'd3, 1, 0, 0, 0, 3'd0, 0, 0};
    vecs[1]  = '{32'h40435293, 32'h104,  32'hF0000000, 32'h1234,  4'hE, 32'hF0000000, 32'd4,        32'h404,      32'd0,    5'd5, 1, 0, 0, 0, 3'd0, 0, 0};
    vecs[2]  = '{32'h0020E463, 32'h108,  32'h11,       32'h22,    4'h8, 32'h11,       32'h22,       32'd8,        32'd0,    5'd0, 0, 0, 0, 1, 3'd6, 0, 0};
    vecs[3]  = '{32'hFFFFFFFF, 32'h10C,  32'h1,        32'h2,     4'h0, 32'd0,        32'd0,        32'd0,        32'd0,    5'd0, 0, 0, 0, 0, 3'd0, 0, 1};
    vecs[4]  = '{32'h00000013, 32'h110,  32'd0,        32'd0,     4'h0, 32'd0,        32'd0,        32'd0,        32'd0,    5'd0, 0, 0, 0, 0, 3'd0, 0, 0};
    vecs[5]  = '{32'h40208233, 32'h114,  32'd10,       32'd3,     4'h2, 32'd10,       32'd3,        32'd0,        32'd0,    5'd4, 1, 0, 0, 0, 3'd0, 0, 0};
    vecs[6]  = '{32'h00C0A283, 32'h118,  32'h100,      32'd0,     4'h0, 32'h100,      32'd12,       32'd12,       32'd0,    5'd5, 1, 1, 0, 0, 3'd0, 0, 0};
    vecs[7]  = '{32'hFE20AE23, 32'h11C,  32'h200,      32'hABCD,  4'h0, 32'h200,      32'hFFFFFFFC, 32'hFFFFFFFC, 32'hABCD, 5'd0, 0, 0, 1, 0, 3'd0, 0, 0};
    vecs[8]  = '{32'h123453B7, 32'h120,  32'h55,       32'h66,    4'h0, 32'd0,        32'h12345000, 32'h12345000, 32'd0,    5'd7, 1, 0, 0, 0, 3'd0, 0, 0};
    vecs[9]  = '{32'h00001417, 32'h1000, 32'h77,       32'h88,    4'h0, 32'h1000,     32'h1000,     32'h1000,     32'd0,    5'd8, 1, 0, 0, 0, 3'd0, 0, 0};
    vecs[10] = '{32'h010000EF, 32'h2000, 32'h9,        32'hA,     4'h0, 32'h2000,     32'd4,        32'd16,       32'd0,    5'd1, 1, 0, 0, 0, 3'd0, 1, 0};
    vecs[11] = '{32'h00009067, 32'h2004, 32'h9,        32'hA,     4'h0, 32'd0,        32'd0,        32'd0,        32'd0,    5'd0, 0, 0, 0, 0, 3'd0, 0, 1};
    vecs[12] = '{32'h008100E7, 32'h3000, 32'h40,       32'hA,     4'h0, 32'h3000,     32'd4,        32'd8,        32'd0,    5'd1, 1, 0, 0, 0, 3'd0, 1, 0};
    vecs[13] = '{32'h40131293, 32'h3004, 32'h1,        32'h2,     4'h0, 32'd0,        32'd0,        32'd0,        32'd0,    5'd0, 0, 0, 0, 0, 3'd0, 0, 1};
    vecs[14] = '{32'h4020F1B3, 32'h3008, 32'h1,        32'h2,     4'h0, 32'd0,        32'd0,        32'd0,        32'd0,    5'd0, 0, 0, 0, 0, 3'd0, 0, 1};
    vecs[15] = '{32'h0020A463, 32'h300C, 32'h1,        32'h2,     4'h0, 32'd0,        32'd0,        32'd0,        32'd0,    5'd0, 0, 0, 0, 0, 3'd0, 0, 1};
    vecs[16] = '{32'hFFF0B193, 32'h3010, 32'd5,        32'h2,     4'h8, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,    5'd3, 1, 0, 0, 0, 3'd0, 0, 0};
    vecs[17] = '{32'h0020C4B3, 32'h3014, 32'hF0F0,     32'h0FF0,  4'h6, 32'hF0F0,     32'h0FF0,     32'd0,        32'd0,    5'd9, 1, 0, 0, 0, 3'd0, 0, 0};

    rst          = 1'b1;
    bus.EX_STALL = 1'b0;
    bus.FLUSH    = 1'b0;
    drive(1'b0, vecs[0]);
    #1;
    check("reset_state", got_pack(), '0);
    check_bit("reset_id_ready", bus.ID_READY, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven: one instruction per cycle, checked #1 after the loading edge
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(1'b1, vecs[i]);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), got_pack(), exp_pack(vecs[i]));
    end

    // ID_VALID=0 loads a bubble
    @(negedge clk);
    drive(1'b0, vecs[5]);
    @(posedge clk);
    #1;
    check("idle_bubble", got_pack(), '0);

    // Hold ADD under stall for 3 cycles while ID changes
    @(negedge clk);
    drive(1'b1, vecs[0]);
    @(posedge clk);
    #1;
    check("stall_load_add", got_pack(), exp_pack(vecs[0]));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      bus.EX_STALL = 1'b1;
      drive(1'b1, vecs[5 + c]);
      #1;
      check_bit($sformatf("stall_ready%0d", c), bus.ID_READY, 1'b0);
      @(posedge clk);
      #1;
      check($sformatf("stall_hold%0d", c), got_pack(), exp_pack(vecs[0]));
    end

    // FLUSH wins over EX_STALL
    @(negedge clk);
    bus.FLUSH = 1'b1;
    @(posedge clk);
    #1;
    check("flush_with_stall", got_pack(), '0);

    // FLUSH alone with a valid instruction also loads a bubble
    @(negedge clk);
    bus.EX_STALL = 1'b0;
    drive(1'b1, vecs[1]);
    @(posedge clk);
    #1;
    check("flush_no_stall", got_pack(), '0);
    @(negedge clk);
    bus.FLUSH = 1'b0;
    @(posedge clk);
    #1;
    check("after_flush_load", got_pack(), exp_pack(vecs[1]));

    // Asynchronous reset while a valid slot is stalled
    @(negedge clk);
    bus.EX_STALL = 1'b1;
    drive(1'b1, vecs[0]);
    @(posedge clk);
    #3;
    check("pre_reset_held", got_pack(), exp_pack(vecs[1]));
    rst = 1'b1;
    #1;
    check("async_reset_clear", got_pack(), '0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_bit("post_reset_valid", bus.EX_VALID, 1'b0);
    check_bit("post_reset_ready", bus.ID_READY, 1'b0);

    // Releasing stall loads the waiting instruction
    @(negedge clk);
    bus.EX_STALL = 1'b0;
    @(posedge clk);
    #1;
    check("post_reset_load", got_pack(), exp_pack(vecs[0]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
